// File: rtl/bram_threshold_engine.sv
// In-place BRAM binarisation: 3 cycles/pixel (RD, CMP, WR), done one cycle after the last write; no backpressure.
// Optional THRESHOLD_COUNT_EN builds the above-threshold pixel counter; otherwise above_count is tied to 0.
module bram_threshold_engine #(
  parameter int ADDR_W   = 15,
  parameter int DATA_W   = 8,
  parameter int IMG_SIZE = 32768
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] threshold,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [ADDR_W-1:0] bram_addr,
  output logic              bram_we,
  output logic [DATA_W-1:0] bram_data_in,
  input  logic [DATA_W-1:0] bram_data_out,
  output logic [ADDR_W:0]   above_count
);

  typedef enum logic [1:0] {IDLE, RD, CMP, WR} state_t;

  // idx is one bit wider than the address so IMG_SIZE == 2**ADDR_W cannot wrap.
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(IMG_SIZE - 1);

  state_t            state_q;
  logic [ADDR_W:0]   idx_q;
  logic [DATA_W-1:0] thr_q;
  logic [DATA_W-1:0] wdat_q;
  logic              busy_q;
  logic              done_q;
  logic              aborted_q;
  logic              we_q;
  logic              hit;

  assign hit = (bram_data_out >= thr_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      thr_q     <= '0;
      wdat_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      we_q      <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      we_q      <= 1'b0;
      if (state_q != IDLE && abort) begin
        // A write already on the bus this cycle completes; nothing follows it.
        state_q   <= IDLE;
        busy_q    <= 1'b0;
        aborted_q <= 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              thr_q   <= threshold;
              idx_q   <= '0;
              busy_q  <= 1'b1;
              state_q <= RD;
            end
          end
          RD: begin
            state_q <= CMP;
          end
          CMP: begin
            wdat_q  <= hit ? '1 : '0;
            we_q    <= 1'b1;
            state_q <= WR;
          end
          WR: begin
            if (idx_q == LAST_IDX) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= RD;
            end
          end
        endcase
      end
    end
  end

`ifdef THRESHOLD_COUNT_EN
  logic [ADDR_W:0] cnt_q;
  logic [ADDR_W:0] above_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      above_q <= '0;
    end else begin
      if (state_q == IDLE && start) begin
        cnt_q <= '0;
      end else if (state_q == CMP && hit) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (state_q == WR && !abort && idx_q == LAST_IDX) begin
        above_q <= cnt_q;
      end
    end
  end

  assign above_count = above_q;
`else
  assign above_count = '0;
`endif

  assign busy         = busy_q;
  assign done         = done_q;
  assign aborted      = aborted_q;
  assign bram_addr    = idx_q[ADDR_W-1:0];
  assign bram_we      = we_q;
  assign bram_data_in = wdat_q;

endmodule

// File: tb/tb_bram_threshold_engine.sv
// Bench for bram_threshold_engine: a 4-pixel instance and a full-address-range 256-pixel instance.
`timescale 1ns/1ps
module tb_bram_threshold_engine;

`ifdef THRESHOLD_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;

  // Small instance: 4 pixels in a 15-bit address space.
  logic        start_s = 1'b0, abort_s = 1'b0;
  logic [7:0]  thr_s = 8'h00;
  logic        busy_s, done_s, aborted_s, we_s;
  logic [14:0] addr_s;
  logic [7:0]  din_s, dout_s;
  logic [15:0] cnt_s;

  // Large instance: IMG_SIZE equals the whole 8-bit address space.
  logic        start_b = 1'b0, abort_b = 1'b0;
  logic [7:0]  thr_b = 8'h00;
  logic        busy_b, done_b, aborted_b, we_b;
  logic [7:0]  addr_b;
  logic [7:0]  din_b, dout_b;
  logic [8:0]  cnt_b;

  bram_threshold_engine #(.ADDR_W(15), .DATA_W(8), .IMG_SIZE(4)) u_small (
    .clk(clk), .rst(rst), .start(start_s), .abort(abort_s), .threshold(thr_s),
    .busy(busy_s), .done(done_s), .aborted(aborted_s), .bram_addr(addr_s),
    .bram_we(we_s), .bram_data_in(din_s), .bram_data_out(dout_s), .above_count(cnt_s)
  );

  bram_threshold_engine #(.ADDR_W(8), .DATA_W(8), .IMG_SIZE(256)) u_big (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .threshold(thr_b),
    .busy(busy_b), .done(done_b), .aborted(aborted_b), .bram_addr(addr_b),
    .bram_we(we_b), .bram_data_in(din_b), .bram_data_out(dout_b), .above_count(cnt_b)
  );

  // Registered-read BRAM models with a bulk-load port used only while idle.
  logic [7:0] mem_s [0:32767];
  logic [7:0] mem_b [0:255];
  logic [7:0] img_s [4];
  logic       ld_s = 1'b0, ld_b = 1'b0;
  logic [7:0] fill_b = 8'h00;

  always @(posedge clk) begin
    if (ld_s) for (int i = 0; i < 4; i++) mem_s[i] <= img_s[i];
    else if (we_s) mem_s[addr_s] <= din_s;
    dout_s <= mem_s[addr_s];
  end

  always @(posedge clk) begin
    if (ld_b) for (int i = 0; i < 256; i++) mem_b[i] <= fill_b;
    else if (we_b) mem_b[addr_b] <= din_b;
    dout_b <= mem_b[addr_b];
  end

  int n_cmp = 0, n_fail = 0;
  logic [7:0]  exp_img [4];
  logic [15:0] scan_cnt;
  logic [15:0] exp_cnt = 16'd0;
  int r_done_cyc, r_ndone, r_nabort, r_bfirst, r_blast, r_nwe;

  // Reference: each pixel independently becomes FF when >= threshold.
  task automatic model_s(input logic [7:0] thr);
    scan_cnt = 16'd0;
    for (int i = 0; i < 4; i++) begin
      exp_img[i] = (img_s[i] >= thr) ? 8'hFF : 8'h00;
      if (img_s[i] >= thr) scan_cnt++;
    end
  endtask

  task automatic load_s();
    ld_s = 1'b1;
    @(posedge clk); #1;
    ld_s = 1'b0;
  endtask

  // Start at cycle 0, then observe cycles 1..25. abort_at/restart_at pick the cycle to drive them.
  task automatic run_s(input int abort_at, input int restart_at);
    r_done_cyc = -1; r_ndone = 0; r_nabort = 0; r_bfirst = -1; r_blast = -1; r_nwe = 0;
    start_s = 1'b1;
    abort_s = (abort_at == 0);
    @(posedge clk); #1;
    for (int c = 1; c <= 25; c++) begin
      abort_s = (c == abort_at);
      start_s = (c == restart_at);
      if (c == restart_at) thr_s = 8'h00;
      if (done_s) begin r_ndone++; r_done_cyc = c; end
      if (aborted_s) r_nabort++;
      if (busy_s) begin if (r_bfirst < 0) r_bfirst = c; r_blast = c; end
      if (we_s) r_nwe++;
      @(posedge clk); #1;
    end
    abort_s = 1'b0;
    start_s = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; #2;
    rst = 1'b0; #1;
    n_cmp++; if ({busy_s, done_s, aborted_s, we_s} !== 4'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", {busy_s, done_s, aborted_s, we_s}); end
    n_cmp++; if (addr_s !== 15'd0 || din_s !== 8'd0) begin n_fail++; $display("FAIL reset_bus: addr %h din %h want 0 0", addr_s, din_s); end
    n_cmp++; if (cnt_s !== 16'd0 || cnt_b !== 9'd0) begin n_fail++; $display("FAIL reset_count: got %h/%h want 0", cnt_s, cnt_b); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    img_s[0] = 8'h10; img_s[1] = 8'h80; img_s[2] = 8'h7F; img_s[3] = 8'hFF;
    load_s();
    thr_s = 8'h80;
    model_s(thr_s);
    run_s(-1, -1);
    exp_cnt = scan_cnt;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (mem_s[i] !== exp_img[i]) begin n_fail++; $display("FAIL basic_px%0d: got %h want %h", i, mem_s[i], exp_img[i]); end
    end
    n_cmp++; if (r_done_cyc !== 13 || r_ndone !== 1) begin n_fail++; $display("FAIL basic_done: cycle %0d count %0d want 13 1", r_done_cyc, r_ndone); end
    n_cmp++; if (r_bfirst !== 1 || r_blast !== 12) begin n_fail++; $display("FAIL basic_busy: %0d..%0d want 1..12", r_bfirst, r_blast); end
    n_cmp++; if (r_nwe !== 4) begin n_fail++; $display("FAIL basic_we: got %0d want 4", r_nwe); end
    n_cmp++; if (cnt_s !== (CNT_EN ? exp_cnt : 16'd0)) begin n_fail++; $display("FAIL basic_count: got %0d want %0d", cnt_s, CNT_EN ? exp_cnt : 16'd0); end
  endtask

  task automatic test_thresholds();
    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < 4; i++) img_s[i] = 8'($urandom);
      thr_s = 8'($urandom);
      if (t == 0) thr_s = 8'h00;
      if (t == 1) begin
        img_s[0] = 8'hFE; img_s[1] = 8'hFF; img_s[2] = 8'h00; img_s[3] = 8'h01; thr_s = 8'hFF;
      end
      load_s();
      model_s(thr_s);
      run_s(-1, -1);
      exp_cnt = scan_cnt;
      for (int i = 0; i < 4; i++) begin
        n_cmp++; if (mem_s[i] !== exp_img[i]) begin n_fail++; $display("FAIL thr%0d_px%0d: got %h want %h (thr %h)", t, i, mem_s[i], exp_img[i], thr_s); end
      end
      n_cmp++; if (cnt_s !== (CNT_EN ? exp_cnt : 16'd0)) begin n_fail++; $display("FAIL thr%0d_count: got %0d want %0d", t, cnt_s, CNT_EN ? exp_cnt : 16'd0); end
    end
  endtask

  task automatic test_abort();
    // Abort in CMP of pixel 2 (cycle 8) then in WR of pixel 1 (cycle 6): pixels 0..1 written either way.
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) img_s[i] = 8'($urandom);
      load_s();
      thr_s = 8'($urandom_range(1, 255));
      model_s(thr_s);
      run_s(k == 0 ? 8 : 6, -1);
      for (int i = 0; i < 4; i++) begin
        if (i >= 2) exp_img[i] = img_s[i];
        n_cmp++; if (mem_s[i] !== exp_img[i]) begin n_fail++; $display("FAIL abort%0d_px%0d: got %h want %h", k, i, mem_s[i], exp_img[i]); end
      end
      n_cmp++; if (r_nabort !== 1 || r_ndone !== 0 || r_nwe !== 2) begin n_fail++; $display("FAIL abort%0d_pulses: aborted %0d done %0d we %0d want 1 0 2", k, r_nabort, r_ndone, r_nwe); end
      n_cmp++; if (cnt_s !== (CNT_EN ? exp_cnt : 16'd0)) begin n_fail++; $display("FAIL abort%0d_count: got %0d want %0d", k, cnt_s, CNT_EN ? exp_cnt : 16'd0); end
    end
    r_nabort = 0;
    abort_s = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (aborted_s || busy_s) r_nabort++;
    end
    abort_s = 1'b0;
    n_cmp++; if (r_nabort !== 0) begin n_fail++; $display("FAIL abort_idle: got %0d reactions want 0", r_nabort); end
    // Start with abort together in IDLE: start wins, scan completes.
    for (int i = 0; i < 4; i++) img_s[i] = 8'($urandom);
    load_s();
    thr_s = 8'($urandom);
    model_s(thr_s);
    run_s(0, -1);
    exp_cnt = scan_cnt;
    n_cmp++; if (r_done_cyc !== 13 || r_nabort !== 0) begin n_fail++; $display("FAIL start_abort_idle: done %0d aborted %0d want 13 0", r_done_cyc, r_nabort); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (mem_s[i] !== exp_img[i]) begin n_fail++; $display("FAIL start_abort_px%0d: got %h want %h", i, mem_s[i], exp_img[i]); end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) img_s[i] = 8'($urandom);
    img_s[0] = img_s[0] | 8'hC0;
    load_s();
    thr_s = 8'h80;
    model_s(8'h80);
    run_s(-1, 5);
    exp_cnt = scan_cnt;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (mem_s[i] !== exp_img[i]) begin n_fail++; $display("FAIL restart_px%0d: got %h want %h", i, mem_s[i], exp_img[i]); end
    end
    n_cmp++; if (r_ndone !== 1 || r_done_cyc !== 13) begin n_fail++; $display("FAIL restart_done: count %0d cycle %0d want 1 13", r_ndone, r_done_cyc); end
    n_cmp++; if (cnt_s !== (CNT_EN ? exp_cnt : 16'd0)) begin n_fail++; $display("FAIL restart_count: got %0d want %0d", cnt_s, CNT_EN ? exp_cnt : 16'd0); end
  endtask

  task automatic test_reset_midwrite();
    for (int i = 0; i < 4; i++) img_s[i] = 8'($urandom);
    load_s();
    thr_s = 8'($urandom);
    start_s = 1'b1;
    @(posedge clk); #1; start_s = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_cmp++; if (we_s !== 1'b1) begin n_fail++; $display("FAIL rstwr_pre_we: got %b want 1", we_s); end
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (we_s !== 1'b0 || busy_s !== 1'b0) begin n_fail++; $display("FAIL rstwr_async: we %b busy %b want 0 0", we_s, busy_s); end
    n_cmp++; if (cnt_s !== 16'd0) begin n_fail++; $display("FAIL rstwr_count: got %0d want 0", cnt_s); end
    exp_cnt = 16'd0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (mem_s[0] !== img_s[0]) begin n_fail++; $display("FAIL rstwr_nowrite: got %h want %h", mem_s[0], img_s[0]); end
    model_s(thr_s);
    run_s(-1, -1);
    exp_cnt = scan_cnt;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (mem_s[i] !== exp_img[i]) begin n_fail++; $display("FAIL rstwr_px%0d: got %h want %h", i, mem_s[i], exp_img[i]); end
    end
    n_cmp++; if (r_done_cyc !== 13 || cnt_s !== (CNT_EN ? exp_cnt : 16'd0)) begin n_fail++; $display("FAIL rstwr_rerun: done %0d count %0d want 13 %0d", r_done_cyc, cnt_s, CNT_EN ? exp_cnt : 16'd0); end
  endtask

  task automatic test_full_range();
    int done_cyc, ndone, last_addr, bad;
    done_cyc = -1; ndone = 0; last_addr = -1; bad = 0;
    fill_b = 8'h80;
    ld_b = 1'b1;
    @(posedge clk); #1; ld_b = 1'b0;
    thr_b = 8'h80;
    start_b = 1'b1;
    @(posedge clk); #1; start_b = 1'b0;
    for (int c = 1; c <= 800; c++) begin
      if (done_b) begin ndone++; done_cyc = c; end
      if (we_b) last_addr = int'(addr_b);
      @(posedge clk); #1;
    end
    for (int i = 0; i < 256; i++) if (mem_b[i] !== 8'hFF) bad++;
    n_cmp++; if (done_cyc !== 769 || ndone !== 1) begin n_fail++; $display("FAIL full_done: cycle %0d count %0d want 769 1", done_cyc, ndone); end
    n_cmp++; if (last_addr !== 255) begin n_fail++; $display("FAIL full_last_addr: got %0d want 255", last_addr); end
    n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL full_pixels: %0d wrong want 0", bad); end
    n_cmp++; if (cnt_b !== (CNT_EN ? 9'h100 : 9'h000)) begin n_fail++; $display("FAIL full_count: got %h want %h", cnt_b, CNT_EN ? 9'h100 : 9'h000); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_thresholds();
    test_abort();
    test_back_to_back();
    test_reset_midwrite();
    test_full_range();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
